spi_mstr_cfg: RTL and testbench

Parametrised, mode-configurable SPI master. It is the next-generation replacement for the fixed 16-bit, mode-0, single-slave master in the sensor interface path. Word width, SCLK rate, trailing delay and slave-select count are set by parameters. CPOL/CPHA and target slave are chosen per transaction. It shifts MSB-first full-duplex and returns the captured MISO word with a one-cycle `done` pulse.

---
 rtl/spi_mstr_cfg.sv | 134 +++++++++++++
 tb/tb_spi_mstr_cfg.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mstr_cfg.sv
// Parametrised SPI master: MSB-first full duplex, per-transaction CPOL/CPHA and slave
// select, captured MISO word returned on resp with a one-cycle done pulse.
//  state | meaning
//  IDLE  | waiting for wrt_cmd; SCLK parked at the last transaction's cpol
//  LEAD  | SS_n asserted, first bit on MOSI, one half-period before the first SCLK edge
//  BITS  | 2*DATA_W SCLK edges; shift/sample on leading/trailing edges per cpha
//  TRAIL | SCLK parked at cpol, SS_n held low for TRAIL_CLKS cycles
module spi_mstr_cfg #(
    parameter int DATA_W     = 16,
    parameter int CLK_DIV    = 32,
    parameter int NUM_SS     = 4,
    parameter int TRAIL_CLKS = 16,
    parameter int SEL_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt_cmd,
    input  logic [DATA_W-1:0] cmd,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_SS-1:0] SS_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] resp
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam int TR_W   = (TRAIL_CLKS > 1) ? $clog2(TRAIL_CLKS) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_W - 1);
    localparam logic [TR_W-1:0]   TRAIL_LAST = TR_W'(TRAIL_CLKS - 1);

    typedef enum logic [1:0] {IDLE, LEAD, BITS, TRAIL} state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [EDGE_W-1:0]  edge_cnt;
    logic [TR_W-1:0]    trail_cnt;
    logic [DATA_W-1:0]  tx_sr;
    logic [DATA_W-1:0]  rx_sr;
    logic               cpha_q;
    logic               sel_ok;
    logic               leading;

    assign sel_ok  = 32'(ss_sel) < NUM_SS;
    assign leading = ~edge_cnt[0];
    // tx_sr is cleared at the end of every transaction so MOSI idles at 0
    assign MOSI    = tx_sr[DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            trail_cnt <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            cpha_q    <= 1'b0;
            SCLK      <= 1'b0;
            SS_n      <= '1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            resp      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // the done cycle is itself IDLE, but a request there is dropped
                    if (wrt_cmd && !done) begin
                        if (sel_ok) begin
                            state    <= LEAD;
                            tx_sr    <= cmd;
                            cpha_q   <= cpha;
                            SCLK     <= cpol;
                            SS_n     <= ~(NUM_SS'(1) << ss_sel);
                            busy     <= 1'b1;
                            div_cnt  <= DIV_LAST;
                            edge_cnt <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LEAD, BITS: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt  <= DIV_LAST;
                        SCLK     <= ~SCLK;
                        edge_cnt <= edge_cnt + 1'b1;
                        state    <= BITS;
                        if (leading) begin
                            if (!cpha_q)
                                rx_sr <= {rx_sr[DATA_W-2:0], MISO};
                            else if (edge_cnt != '0)
                                tx_sr <= tx_sr << 1;
                        end else begin
                            if (cpha_q)
                                rx_sr <= {rx_sr[DATA_W-2:0], MISO};
                            else
                                tx_sr <= tx_sr << 1;
                        end
                        if (edge_cnt == EDGE_LAST) begin
                            state     <= TRAIL;
                            trail_cnt <= TRAIL_LAST;
                        end
                    end
                end
                TRAIL: begin
                    if (trail_cnt != '0) begin
                        trail_cnt <= trail_cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                        SS_n  <= '1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        resp  <= rx_sr;
                        tx_sr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mstr_cfg.sv
// Bench for spi_mstr_cfg: closed-form cycle model of the default instance, a bit-level
// SPI slave, directed literal checks and randomized transactions; small second instance.
module tb_spi_mstr_cfg;

    localparam int DW    = 16;
    localparam int CD    = 32;
    localparam int NSS   = 4;
    localparam int TR    = 16;
    localparam int TOTAL = 2 * DW * CD + TR;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wrt_cmd;
    logic [15:0]   cmd;
    logic [1:0]    ss_sel;
    logic          cpol, cpha;
    logic          miso;
    logic          sclk, mosi, busy, done, err;
    logic [3:0]    ss_n;
    logic [15:0]   resp;

    logic          s_wrt;
    logic [7:0]    s_cmd;
    logic [1:0]    s_sel;
    logic          s_cpol, s_cpha;
    logic          s_sclk, s_mosi, s_busy, s_done, s_err;
    logic [2:0]    s_ss_n;
    logic [7:0]    s_resp;

    logic          miso_mode;
    logic [15:0]   slave_word;
    logic          sl_miso;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign miso = miso_mode ? sl_miso : mosi;

    spi_mstr_cfg u_dut (
        .clk(clk), .rst_n(rst_n), .wrt_cmd(wrt_cmd), .cmd(cmd), .ss_sel(ss_sel),
        .cpol(cpol), .cpha(cpha), .MISO(miso), .SCLK(sclk), .MOSI(mosi),
        .SS_n(ss_n), .busy(busy), .done(done), .err(err), .resp(resp)
    );

    spi_mstr_cfg #(.DATA_W(8), .CLK_DIV(2), .NUM_SS(3), .TRAIL_CLKS(1)) u_small (
        .clk(clk), .rst_n(rst_n), .wrt_cmd(s_wrt), .cmd(s_cmd), .ss_sel(s_sel),
        .cpol(s_cpol), .cpha(s_cpha), .MISO(s_mosi), .SCLK(s_sclk), .MOSI(s_mosi),
        .SS_n(s_ss_n), .busy(s_busy), .done(s_done), .err(s_err), .resp(s_resp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t is the cycle number within the transaction (1 = first busy cycle)
    logic        m_active, m_done, m_err, m_cpol, m_cpha, m_idle_sclk;
    int          m_t;
    logic [15:0] m_word, m_rx, m_resp;
    logic [1:0]  m_sel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_t <= 0;
            m_resp <= '0; m_idle_sclk <= 1'b0; m_word <= '0; m_rx <= '0;
            m_cpol <= 1'b0; m_cpha <= 1'b0; m_sel <= '0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_active) begin
                if (m_t == TOTAL) begin
                    m_active <= 1'b0; m_done <= 1'b1; m_resp <= m_rx; m_idle_sclk <= m_cpol;
                end else begin
                    m_t <= m_t + 1;
                end
            end else if (!m_done && wrt_cmd) begin
                if (int'(ss_sel) < NSS) begin
                    m_active <= 1'b1; m_t <= 1; m_word <= cmd; m_sel <= ss_sel;
                    m_cpol <= cpol; m_cpha <= cpha;
                    m_rx <= miso_mode ? slave_word : cmd;
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    function automatic int edges_seen();
        int k;
        k = (m_t - 1) / CD;
        return (k > 2 * DW) ? 2 * DW : k;
    endfunction

    function automatic logic exp_sclk();
        int k;
        if (!m_active) return m_idle_sclk;
        k = edges_seen();
        return m_cpol ^ k[0];
    endfunction

    function automatic logic exp_mosi();
        int k, sh;
        if (!m_active) return 1'b0;
        k  = edges_seen();
        sh = m_cpha ? ((k + 1) / 2 - 1) : k / 2;
        if (sh < 0) sh = 0;
        if (sh >= DW) return 1'b0;
        return m_word[DW-1-sh];
    endfunction

    initial begin
        logic [3:0] e_ss;
        forever begin
            @(negedge clk);
            e_ss = 4'hF;
            if (m_active) e_ss[m_sel] = 1'b0;
            chk("sclk", sclk, exp_sclk());
            chk("mosi", mosi, exp_mosi());
            chk("ss_n", ss_n, e_ss);
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("err",  err,  m_err);
            chk("resp", resp, m_resp);
        end
    end

    // SPI slave: counts SCLK toggles while selected, drives its word, captures MOSI
    initial begin
        int          sl_cnt;
        logic [15:0] sl_rx;
        logic        ss_prev_low, sclk_prev;
        sl_cnt = 0; sl_rx = '0; ss_prev_low = 1'b0; sclk_prev = 1'b0; sl_miso = 1'b0;
        forever begin
            @(negedge clk);
            if (&ss_n) begin
                if (ss_prev_low && m_done && miso_mode) chk("slave_mosi_word", sl_rx, m_word);
                sl_cnt = 0;
                sl_rx  = '0;
            end else if (ss_prev_low && sclk !== sclk_prev) begin
                sl_cnt++;
                if ((sl_cnt % 2) == (m_cpha ? 0 : 1)) sl_rx = {sl_rx[14:0], mosi};
            end
            ss_prev_low = !(&ss_n);
            sclk_prev   = sclk;
            sl_miso     = (sl_cnt / 2 < DW) ? slave_word[DW-1-sl_cnt/2] : 1'b0;
        end
    end

    task automatic start_txn(input logic [15:0] c, input logic [1:0] s, input logic p, input logic h);
        @(negedge clk);
        cmd = c; ss_sel = s; cpol = p; cpha = h; wrt_cmd = 1'b1;
        @(negedge clk);
        wrt_cmd = 1'b0;
    endtask

    task automatic wait_done(input int cyc0, output int cyc, output int edges);
        logic prev;
        prev = sclk; cyc = cyc0; edges = 0;
        while (!done && cyc < TOTAL + 50) begin
            @(negedge clk);
            cyc++;
            if (sclk !== prev) edges++;
            prev = sclk;
        end
        chk("done_seen", done, 1'b1);
    endtask

    initial begin
        int cyc, ed;
        rst_n = 1'b1; wrt_cmd = 1'b0; cmd = '0; ss_sel = '0; cpol = 1'b0; cpha = 1'b0;
        s_wrt = 1'b0; s_cmd = '0; s_sel = '0; s_cpol = 1'b0; s_cpha = 1'b0;
        miso_mode = 1'b0; slave_word = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", ss_n, 4'hF);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_resp", resp, 16'h0);
        #2 rst_n = 1'b1;

        // mode 0 loopback, slave 0
        start_txn(16'hA5C3, 2'd0, 1'b0, 1'b0);
        chk("t1_ss_n", ss_n, 4'b1110);
        chk("t1_busy", busy, 1'b1);
        wait_done(1, cyc, ed);
        chk("t1_done_cycle", cyc, 1041);
        chk("t1_edges", ed, 32);
        chk("t1_resp", resp, 16'hA5C3);

        // mode 3, slave 2 returning 0x1234
        miso_mode = 1'b1; slave_word = 16'h1234;
        start_txn(16'h5A96, 2'd2, 1'b1, 1'b1);
        chk("t2_ss_n", ss_n, 4'b1011);
        chk("t2_sclk_lead", sclk, 1'b1);
        wait_done(1, cyc, ed);
        chk("t2_done_cycle", cyc, 1041);
        chk("t2_resp", resp, 16'h1234);
        @(negedge clk);
        chk("t2_sclk_idle", sclk, 1'b1);

        // request mid-BITS is ignored
        miso_mode = 1'b0;
        start_txn(16'h0001, 2'd1, 1'b0, 1'b0);
        repeat (400) @(negedge clk);
        cmd = 16'hFFFF; wrt_cmd = 1'b1;
        @(negedge clk);
        wrt_cmd = 1'b0;
        wait_done(402, cyc, ed);
        chk("t3_done_cycle", cyc, 1041);
        chk("t3_resp", resp, 16'h0001);
        repeat (3) @(negedge clk);
        chk("t3_no_restart", busy, 1'b0);

        // wrt_cmd held high: back-to-back with one idle cycle after done
        @(negedge clk);
        cmd = 16'h1357; ss_sel = 2'd3; cpol = 1'b0; cpha = 1'b0; wrt_cmd = 1'b1;
        @(negedge clk);
        wait_done(1, cyc, ed);
        chk("b2b_done_busy", busy, 1'b0);
        @(negedge clk);
        chk("b2b_idle_busy", busy, 1'b0);
        chk("b2b_idle_ss_n", ss_n, 4'hF);
        @(negedge clk);
        chk("b2b_restart_busy", busy, 1'b1);
        chk("b2b_restart_ss_n", ss_n, 4'b0111);
        wrt_cmd = 1'b0;
        wait_done(1, cyc, ed);
        chk("b2b_resp", resp, 16'h1357);

        // asynchronous reset at cycle 300, then a fresh transfer
        start_txn(16'hBEEF, 2'd3, 1'b1, 1'b0);
        repeat (299) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ss_n", ss_n, 4'hF);
        chk("rst_mid_sclk", sclk, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_mosi", mosi, 1'b0);
        chk("rst_mid_resp", resp, 16'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        start_txn(16'h6E2D, 2'd0, 1'b0, 1'b1);
        wait_done(1, cyc, ed);
        chk("t5_done_cycle", cyc, 1041);
        chk("t5_resp", resp, 16'h6E2D);

        // randomized transactions with stray requests while busy
        for (int i = 0; i < 18; i++) begin
            miso_mode  = 1'($urandom_range(0, 1));
            slave_word = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_txn(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            cyc = 1;
            while (!done && cyc < TOTAL + 50) begin
                @(negedge clk);
                cyc++;
                if (!done && $urandom_range(0, 63) == 0) begin
                    wrt_cmd = 1'b1; cmd = 16'($urandom); ss_sel = 2'($urandom_range(0, 3));
                    cpol = 1'($urandom_range(0, 1)); cpha = 1'($urandom_range(0, 1));
                end else begin
                    wrt_cmd = 1'b0;
                end
            end
            wrt_cmd = 1'b0;
            chk("rnd_done_seen", done, 1'b1);
            chk("rnd_done_cycle", cyc, TOTAL + 1);
        end

        // small instance: NUM_SS=3 rejects ss_sel=3
        @(negedge clk);
        s_sel = 2'd3; s_cmd = 8'h55; s_wrt = 1'b1;
        @(negedge clk);
        s_wrt = 1'b0;
        chk("s_err_pulse", s_err, 1'b1);
        chk("s_err_ss_n", s_ss_n, 3'b111);
        chk("s_err_busy", s_busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s_err_clear", s_err, 1'b0);
            chk("s_err_idle_busy", s_busy, 1'b0);
            chk("s_err_idle_sclk", s_sclk, 1'b0);
            chk("s_err_idle_ss_n", s_ss_n, 3'b111);
        end

        // small instance: DATA_W=8, CLK_DIV=2, TRAIL_CLKS=1 loopback
        @(negedge clk);
        s_cmd = 8'h3C; s_sel = 2'd1; s_cpol = 1'b0; s_cpha = 1'b0; s_wrt = 1'b1;
        @(negedge clk);
        s_wrt = 1'b0;
        chk("s_ss_n", s_ss_n, 3'b101);
        cyc = 1;
        while (!s_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("s_done_seen", s_done, 1'b1);
        chk("s_done_cycle", cyc, 34);
        chk("s_resp", s_resp, 8'h3C);
        chk("s_done_ss_n", s_ss_n, 3'b111);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
